fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//   Parametrised instruction-fetch front end with a DEPTH-entry prefetch queue.
//   Streams sequential fetches, one request per cycle, while the decode stage is stalled.
//   Sits between instruction memory and decode; redirects on flush with alignment checking.
//   Supersedes the single-entry fetch stage.
// PARAMETERS
//   ADDR_W    32  address width (PC, memory address, flush address)
//   INSTR_W   32  instruction width
//   DEPTH     4   prefetch queue entries; power of 2, >= 2
//   RESET_PC  0   fetch address after reset; must be 4-byte aligned
// PORTS
//   clk            in   1        clock, rising edge
//   reset          in   1        asynchronous, active-high reset
//   mem_rd_addr    out  ADDR_W   fetch address (always equals fetch_pc)
//   mem_rd_enable  out  1        read request
//   mem_rd_data    in   INSTR_W  read data; valid in the cycle mem_rd_ready=1
//   mem_rd_ready   in   1        request accepted and data returned, same cycle
//   instr          out  INSTR_W  instruction at queue head
//   PC             out  ADDR_W   address of instruction at queue head
//   pipeline_valid out  1        head entry valid for decode
//   stall          in   1        decode not accepting; pop = pipeline_valid & !stall
//   flush          in   1        redirect request
//   flush_addr     in   ADDR_W   redirect target
//   misalign_err   out  1        1-cycle pulse: flush_addr[1:0] != 0 at flush
//   fill_level     out  log2(DEPTH)+1  current queue occupancy
// BEHAVIOUR
// - Reset (async)
//   - Values: fetch_pc=RESET_PC; queue empty; rd/wr pointers=0; all entries=0.
//   - Outputs: mem_rd_enable=0, mem_rd_addr=RESET_PC, pipeline_valid=0, instr=0, PC=0,
//     misalign_err=0, fill_level=0.
//   - Assertion mid-transfer drops the queue and any pending request immediately.
// - Issue
//   - mem_rd_enable = !reset & !flush & (fill_level < DEPTH). Combinational.
//   - No bypass of the same-cycle pop: a full queue issues again only in the cycle after a pop.
//   - mem_rd_addr = fetch_pc.
//   - The memory may see enable withdrawn without ready (on flush or full queue).
//     It must keep no state for an unaccepted request.
// - Accept (mem_rd_enable & mem_rd_ready)
//   - At the clock edge: push {fetch_pc, mem_rd_data}; fetch_pc += 4, modulo 2^ADDR_W.
//     Wrap from all-ones-minus-3 to 0 is legal and silent.
//   - Peak throughput: 1 instruction/cycle.
// - Output
//   - Show-ahead: instr, PC and pipeline_valid are driven from the queue head.
//   - pipeline_valid = (fill_level != 0) & !flush.
//   - Latency: a word accepted in cycle t is visible at the head in cycle t+1 if the queue was empty.
//   - If the head does not pop (stall=1), instr, PC and pipeline_valid are held.
// - Occupancy
//   - Push and pop in the same cycle leave fill_level unchanged.
//   - Push while full: impossible by construction.
//   - Pop while empty: ignored.
//   - Pointers are log2(DEPTH) bits and wrap naturally.
// - Flush (highest priority after reset)
//   - Same cycle: pipeline_valid=0, mem_rd_enable=0; any mem_rd_ready/data is discarded.
//   - At the edge: queue emptied, fetch_pc = {flush_addr[ADDR_W-1:2], 2'b00}.
//     misalign_err=1 for the next cycle if flush_addr[1:0]!=0.
//   - Fetch resumes the cycle after flush deasserts.
//   - Back-to-back flushes: the last one wins.
//   - flush overrides a simultaneous stall, pop or accept.
// - Stall
//   - Affects only popping; prefetch continues until fill_level == DEPTH.
// TESTING
// - Reset release, mem_rd_ready tied 1, stall=0:
//   - Requests go to 0x0, 0x4, 0x8, ... on consecutive cycles.
//   - PC shows 0x0 with pipeline_valid=1 one cycle after the first accept, then +4 every cycle.
// - stall=1 from cycle 0, DEPTH=4, ready tied 1:
//   - Exactly 4 accepts (0x0-0xC), then mem_rd_enable=0 and fill_level=4, PC held at 0x0.
//   - After stall falls, mem_rd_enable reasserts one cycle after the first pop, address 0x10.
// - Queue holds 3 entries, flush with flush_addr=0x100 while mem_rd_ready=1:
//   - Accept dropped, fill_level=0 next cycle.
//   - Next request address is 0x100; no stale instruction is ever presented.
// - Flush with flush_addr=0x102:
//   - misalign_err pulses for 1 cycle; the next fetch address is 0x100.
// - Random mem_rd_ready (50%) and random stall over 10k cycles:
//   - Decoded PC sequence strictly +4 and instr matches the memory model; fill_level <= DEPTH always.
// - reset asserted mid-stream (queue 2 full, request pending):
//   - Outputs go to reset values without waiting for a clock edge.
//   - Fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues sequential reads into a DEPTH-entry show-ahead
// prefetch queue feeding decode, with flush redirect and misaligned-target reporting.
module fetch_queue #(
    parameter int                  ADDR_W   = 32,
    parameter int                  INSTR_W  = 32,
    parameter int                  DEPTH    = 4,
    parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic [ADDR_W-1:0]          mem_rd_addr,
    output logic                       mem_rd_enable,
    input  logic [INSTR_W-1:0]         mem_rd_data,
    input  logic                       mem_rd_ready,
    output logic [INSTR_W-1:0]         instr,
    output logic [ADDR_W-1:0]          PC,
    output logic                       pipeline_valid,
    input  logic                       stall,
    input  logic                       flush,
    input  logic [ADDR_W-1:0]          flush_addr,
    output logic                       misalign_err,
    output logic [$clog2(DEPTH):0]     fill_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W+1)'(DEPTH);

    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic               misalign_q, misalign_d;
    logic [ADDR_W-1:0]  pc_mem_q [DEPTH];
    logic [INSTR_W-1:0] data_mem_q [DEPTH];

    logic accept;
    logic pop;

    // Valid/ready: a memory word is taken only in a cycle where enable and ready are both
    // high; decode takes the head only in a cycle where pipeline_valid is high and stall low.
    assign mem_rd_enable  = !reset && !flush && (count_q != FULL_LEVEL);
    assign mem_rd_addr    = fetch_pc_q;
    assign accept         = mem_rd_enable && mem_rd_ready;
    assign pipeline_valid = (count_q != '0) && !flush;
    assign pop            = pipeline_valid && !stall;

    assign instr        = data_mem_q[rd_ptr_q];
    assign PC           = pc_mem_q[rd_ptr_q];
    assign misalign_err = misalign_q;
    assign fill_level   = count_q;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        misalign_d = 1'b0;
        if (flush) begin
            // Redirect wins over any accept or pop in the same cycle.
            fetch_pc_d = {flush_addr[ADDR_W-1:2], 2'b00};
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            misalign_d = (flush_addr[1:0] != 2'b00);
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + ADDR_W'(4);
                wr_ptr_d   = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({accept, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                data_mem_q[i] <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
            if (accept && !flush) begin
                pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
                data_mem_q[wr_ptr_q] <= mem_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus a long random run, checked every cycle
// against a queue-based reference of the fetch stream.
module tb_fetch_queue;

    localparam int AW = 32;
    localparam int IW = 32;
    localparam int DEPTH = 4;
    localparam logic [AW-1:0] RESET_PC = 32'h0;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] mem_rd_addr;
    logic          mem_rd_enable;
    logic [IW-1:0] mem_rd_data;
    logic          mem_rd_ready;
    logic [IW-1:0] instr;
    logic [AW-1:0] PC;
    logic          pipeline_valid;
    logic          stall;
    logic          flush;
    logic [AW-1:0] flush_addr;
    logic          misalign_err;
    logic [2:0]    fill_level;

    int n_checks = 0;
    int n_pass   = 0;

    fetch_queue #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset),
        .mem_rd_addr(mem_rd_addr), .mem_rd_enable(mem_rd_enable),
        .mem_rd_data(mem_rd_data), .mem_rd_ready(mem_rd_ready),
        .instr(instr), .PC(PC), .pipeline_valid(pipeline_valid),
        .stall(stall), .flush(flush), .flush_addr(flush_addr),
        .misalign_err(misalign_err), .fill_level(fill_level)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Memory returns the word for whatever address is presented.
    assign mem_rd_data = mem_word(mem_rd_addr);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference: the queue of fetched {pc, instr} pairs and the next fetch address.
    logic [AW-1:0] exp_pc_q[$];
    logic [IW-1:0] exp_q[$];
    logic [AW-1:0] model_pc;
    logic          exp_mis;

    always @(negedge clk) begin
        logic exp_en, exp_pv;
        if (reset) begin
            chk("rst_en", 64'(mem_rd_enable), 64'(0));
            chk("rst_pv", 64'(pipeline_valid), 64'(0));
            chk("rst_fill", 64'(fill_level), 64'(0));
            chk("rst_addr", 64'(mem_rd_addr), 64'(RESET_PC));
            chk("rst_mis", 64'(misalign_err), 64'(0));
            exp_pc_q.delete();
            exp_q.delete();
            model_pc = RESET_PC;
            exp_mis  = 1'b0;
        end else begin
            exp_en = !flush && (exp_q.size() < DEPTH);
            exp_pv = (exp_q.size() != 0) && !flush;
            chk("enable", 64'(mem_rd_enable), 64'(exp_en));
            chk("pipeline_valid", 64'(pipeline_valid), 64'(exp_pv));
            chk("fill_level", 64'(fill_level), 64'(exp_q.size()));
            chk("mem_rd_addr", 64'(mem_rd_addr), 64'(model_pc));
            chk("misalign_err", 64'(misalign_err), 64'(exp_mis));
            if (exp_pv && pipeline_valid) begin
                chk("head_pc", 64'(PC), 64'(exp_pc_q[0]));
                chk("head_instr", 64'(instr), 64'(exp_q[0]));
            end
            if (flush) begin
                exp_pc_q.delete();
                exp_q.delete();
                model_pc = {flush_addr[AW-1:2], 2'b00};
                exp_mis  = (flush_addr[1:0] != 2'b00);
            end else begin
                exp_mis = 1'b0;
                if (exp_pv && !stall) begin
                    void'(exp_pc_q.pop_front());
                    void'(exp_q.pop_front());
                end
                if (exp_en && mem_rd_ready) begin
                    exp_pc_q.push_back(model_pc);
                    exp_q.push_back(mem_word(model_pc));
                    model_pc = model_pc + 32'd4;
                end
            end
            if (exp_q.size() > DEPTH) chk("model_overflow", 64'(exp_q.size()), 64'(DEPTH));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_flush(input logic [AW-1:0] a);
        flush = 1'b1;
        flush_addr = a;
        step(1);
        flush = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        flush_addr = '0;
        mem_rd_ready = 1'b0;
        step(3);
        reset = 1'b0;

        // Free-running sequential fetch.
        mem_rd_ready = 1'b1;
        step(10);

        // Stalled decode: fill to DEPTH, then drain.
        stall = 1'b1;
        do_flush(32'h0);
        step(12);
        stall = 1'b0;
        step(8);

        // Flush with three entries queued and ready high.
        stall = 1'b1;
        do_flush(32'h200);
        step(3);
        do_flush(32'h100);
        stall = 1'b0;
        step(6);

        // Misaligned target, then back-to-back flushes.
        do_flush(32'h102);
        step(6);
        flush = 1'b1;
        flush_addr = 32'h300;
        step(1);
        flush_addr = 32'h403;
        step(1);
        flush = 1'b0;
        step(6);

        // Address wrap through zero.
        do_flush(32'hFFFF_FFF8);
        step(6);

        // Random traffic.
        for (int i = 0; i < 10000; i++) begin
            mem_rd_ready = 1'($urandom_range(0, 1));
            stall        = 1'($urandom_range(0, 1));
            flush        = ($urandom_range(0, 49) == 0);
            flush_addr   = $urandom();
            step(1);
        end
        flush = 1'b0;
        stall = 1'b0;
        mem_rd_ready = 1'b1;
        step(4);

        // Asynchronous reset mid-stream: two entries queued, request pending.
        stall = 1'b1;
        do_flush(32'h40);
        step(2);
        mem_rd_ready = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("async_en", 64'(mem_rd_enable), 64'(0));
        chk("async_pv", 64'(pipeline_valid), 64'(0));
        chk("async_fill", 64'(fill_level), 64'(0));
        chk("async_addr", 64'(mem_rd_addr), 64'(RESET_PC));
        chk("async_instr", 64'(instr), 64'(0));
        chk("async_pc", 64'(PC), 64'(0));
        step(1);
        reset = 1'b0;
        stall = 1'b0;
        mem_rd_ready = 1'b1;
        step(8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
